// File: rtl/multiplexer_pkg.sv
// Shared datapath definitions for the 32-bit RISC core: the address width,
// the address type and the encodings of the memory-address source select.
package riscv_pkg;

  localparam int unsigned ADDR_W = 28;

  typedef logic [ADDR_W-1:0] addr_t;

  // Select encodings for the memory-address source.
  localparam logic SEL_PC = 1'b1;
  localparam logic SEL_IR = 1'b0;

endpackage : riscv_pkg

// File: rtl/multiplexer_if.sv
// Address-source bus between the fetch/decode control and the memory
// controller: select and address inputs, plus the selected and registered outputs.
interface multiplexer_if #(
  parameter int unsigned ADDR_W = riscv_pkg::ADDR_W
);

  logic              fetch;
  logic [ADDR_W-1:0] irout;
  logic [ADDR_W-1:0] pcout;
  logic [ADDR_W-1:0] address;
  logic [ADDR_W-1:0] address_q;
  logic              fetch_q;
  logic              sel_change;

  // Control side: drives the select and both candidate addresses.
  modport master (
    output fetch, irout, pcout,
    input  address, address_q, fetch_q, sel_change
  );

  // Selector side: the multiplexer itself.
  modport slave (
    input  fetch, irout, pcout,
    output address, address_q, fetch_q, sel_change
  );

endinterface : multiplexer_if

// File: rtl/multiplexer.sv
// Memory-address source selector: picks the PC during fetch and the IR address
// field otherwise, with a registered copy of address/select and a select-change flag.
module multiplexer #(
  parameter int unsigned              ADDR_W   = riscv_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0]        RST_ADDR = '0
) (
  input  logic          clk,
  input  logic          rst,
  multiplexer_if.slave  bus
);

  import riscv_pkg::*;

  logic [ADDR_W-1:0] address_d;
  logic [ADDR_W-1:0] address_q;
  logic              fetch_d;
  logic              fetch_q;

  // A plain ternary keeps an X select visible on the address rather than masking it.
  always_comb begin
    address_d = bus.fetch ? bus.pcout : bus.irout;
    fetch_d   = bus.fetch;
  end

  // NOTE: non-blocking assignments here so every register samples the pre-edge
  // values; the reset branch is asynchronous and needs no clock to take effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      address_q <= RST_ADDR;
      fetch_q   <= SEL_IR;
    end else begin
      address_q <= address_d;
      fetch_q   <= fetch_d;
    end
  end

  assign bus.address    = address_d;
  assign bus.address_q  = address_q;
  assign bus.fetch_q    = fetch_q;
  assign bus.sel_change = bus.fetch ^ fetch_q;

endmodule : multiplexer

// File: tb/tb_multiplexer.sv
// Self-checking bench for the address-source selector: directed scenarios plus
// randomized traffic compared against a cycle-level reference model.
module tb_multiplexer;

  localparam int unsigned AW = 28;
  localparam logic [AW-1:0] AMASK = {AW{1'b1}};

  logic clk;
  logic rst;

  multiplexer_if #(.ADDR_W(AW)) bus ();

  multiplexer #(.ADDR_W(AW), .RST_ADDR('0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  // Reference model: what the register stage should hold, taken from the
  // stimulus this bench drove at each rising edge while out of reset.
  logic [AW-1:0] exp_addr_q;
  logic          exp_fetch_q;

  always @(posedge clk) begin
    if (!rst) begin
      exp_addr_q  <= bus.fetch ? bus.pcout : bus.irout;
      exp_fetch_q <= bus.fetch;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare every output against the model for the currently driven inputs.
  task automatic check_all(input string tag);
    logic [AW-1:0] sel;
    sel = bus.fetch ? bus.pcout : bus.irout;
    check({tag, ".address"},    32'(bus.address),    32'(sel));
    check({tag, ".address_q"},  32'(bus.address_q),  32'(exp_addr_q));
    check({tag, ".fetch_q"},    32'(bus.fetch_q),    32'(exp_fetch_q));
    check({tag, ".sel_change"}, 32'(bus.sel_change), 32'(bus.fetch != exp_fetch_q));
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset state.
    rst         = 1'b1;
    exp_addr_q  = '0;
    exp_fetch_q = 1'b0;
    bus.fetch   = 1'b0;
    bus.irout   = 28'h2345678;
    bus.pcout   = 28'hBCDEF01;
    #1;
    check("rst.address_q",  32'(bus.address_q),  32'h0);
    check("rst.fetch_q",    32'(bus.fetch_q),    32'h0);
    check("rst.address",    32'(bus.address),    32'h2345678);
    check("rst.sel_change", 32'(bus.sel_change), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_held.address_q", 32'(bus.address_q), 32'h0);

    // Release reset and select the PC.
    @(negedge clk);
    rst       = 1'b0;
    bus.fetch = 1'b1;
    #1;
    check("fetch.address",    32'(bus.address),    32'hBCDEF01);
    check("fetch.sel_change", 32'(bus.sel_change), 32'h1);
    check("fetch.address_q",  32'(bus.address_q),  32'h0);
    @(posedge clk);
    #1;
    check("fetch_edge.address_q",  32'(bus.address_q),  32'hBCDEF01);
    check("fetch_edge.fetch_q",    32'(bus.fetch_q),    32'h1);
    check("fetch_edge.sel_change", 32'(bus.sel_change), 32'h0);

    // Toggle the select every 5 ns, away from the rising edges.
    #1;
    for (int i = 0; i < 4; i++) begin
      bus.fetch = ~bus.fetch;
      #1;
      check_all("toggle");
      check("toggle.value", 32'(bus.address), bus.fetch ? 32'hBCDEF01 : 32'h2345678);
      #4;
    end
    #4;
    check_all("toggle_end");

    // Increment both sources every 10 ns with a random select.
    for (int i = 0; i < 20; i++) begin
      bus.irout = bus.irout + 1'b1;
      bus.pcout = bus.pcout + 1'b1;
      bus.fetch = 1'($urandom_range(0, 1));
      #1;
      check_all("incr");
      #9;
    end
    bus.fetch = 1'b0;
    #1;
    check("incr_final.irout", 32'(bus.address), 32'h234568C);
    bus.fetch = 1'b1;
    #1;
    check("incr_final.pcout", 32'(bus.address), 32'hBCDEF15);

    // Randomized traffic, changing inputs on either clock phase.
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #($urandom_range(1, 8));
      bus.irout = AW'($urandom) & AMASK;
      bus.pcout = AW'($urandom) & AMASK;
      bus.fetch = 1'($urandom_range(0, 1));
      #1;
      check_all("rand");
    end

    // PC wrap-around at the top of the address space.
    @(negedge clk);
    bus.pcout = 28'hFFFFFFF;
    bus.fetch = 1'b1;
    #1;
    check("wrap.before", 32'(bus.address), 32'hFFFFFFF);
    bus.pcout = bus.pcout + 1'b1;
    #1;
    check("wrap.address", 32'(bus.address), 32'h0);
    check_all("wrap");
    @(posedge clk);
    #1;
    check("wrap.address_q", 32'(bus.address_q), 32'h0);
    check_all("wrap_edge");

    // Asynchronous reset pulse between rising edges.
    @(negedge clk);
    bus.irout = 28'h1234567;
    bus.fetch = 1'b0;
    @(posedge clk);
    #1;
    check("arst.pre_address_q", 32'(bus.address_q), 32'h1234567);
    #2;
    rst         = 1'b1;
    exp_addr_q  = '0;
    exp_fetch_q = 1'b0;
    #1;
    check("arst.address_q", 32'(bus.address_q), 32'h0);
    check("arst.fetch_q",   32'(bus.fetch_q),   32'h0);
    bus.fetch = 1'b1;
    bus.pcout = 28'h0ABCDEF;
    #0.5;
    check("arst.address_live", 32'(bus.address), 32'h0ABCDEF);
    check_all("arst_in");
    #0.5;
    rst = 1'b0;
    #1;
    check("arst.hold_address_q", 32'(bus.address_q), 32'h0);
    check_all("arst_released");
    @(posedge clk);
    #1;
    check("arst.recover_address_q", 32'(bus.address_q), 32'h0ABCDEF);
    check_all("arst_recover");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_multiplexer
